// File: rtl/ft245_sync_xcvr.sv
// FT2232H FT245 synchronous-FIFO transceiver: half-duplex bus sequencer with
// round-robin RX/TX burst arbitration and first-word-fall-through byte FIFOs.
module ft245_sync_xcvr #(
   parameter int unsigned RX_DEPTH  = 512,
   parameter int unsigned TX_DEPTH  = 512,
   parameter int unsigned MAX_BURST = 64,
   parameter bit          TX_FIRST  = 1'b0
) (
   input  logic                      uclk_i,
   input  logic                      rst_i,
   input  logic                      pwren_i,
   input  logic                      rxf_i,
   input  logic                      txe_i,
   output logic                      oe_o,
   output logic                      rd_o,
   output logic                      wr_o,
   output logic                      siwu_o,
   input  logic [7:0]                data_i,
   output logic [7:0]                data_o,
   output logic                      data_oe_o,
   output logic [7:0]                rx_data_o,
   output logic                      rx_valid_o,
   input  logic                      rx_ready_i,
   input  logic [7:0]                tx_data_i,
   input  logic                      tx_valid_i,
   output logic                      tx_ready_o,
   input  logic                      siwu_i,
   output logic [$clog2(RX_DEPTH):0] rx_level_o,
   output logic [$clog2(TX_DEPTH):0] tx_level_o
);
   localparam int unsigned RAW = $clog2(RX_DEPTH);
   localparam int unsigned TAW = $clog2(TX_DEPTH);
   localparam logic [RAW:0] RxFull   = RX_DEPTH[RAW:0];
   localparam logic [TAW:0] TxFull   = TX_DEPTH[TAW:0];
   localparam logic [7:0]   MaxBurst = MAX_BURST[7:0];

   typedef enum logic [1:0] {StIdle, StRxOe, StRxRd, StTxWr} state_e;

   state_e       state_q, state_d;
   logic         oe_q, oe_d, rd_q, rd_d, wr_q, wr_d, siwu_q, siwu_d;
   logic         data_oe_q, data_oe_d;
   logic         last_tx_q, last_tx_d, pend_q, pend_d;
   logic [7:0]   burst_cnt_q, burst_cnt_d;

   logic [7:0]   rx_mem [RX_DEPTH];
   logic [7:0]   tx_mem [TX_DEPTH];
   logic [RAW:0] rx_wptr_q, rx_rptr_q, rx_level_nxt;
   logic [TAW:0] tx_wptr_q, tx_rptr_q, tx_level_nxt;
   logic         rx_push, rx_pop, tx_push, tx_pop, rx_req, tx_req;

   assign rx_level_o = rx_wptr_q - rx_rptr_q;
   assign tx_level_o = tx_wptr_q - tx_rptr_q;
   assign rx_valid_o = (rx_level_o != '0);
   assign tx_ready_o = (tx_level_o != TxFull);
   assign rx_data_o  = rx_mem[rx_rptr_q[RAW-1:0]];

   // Strobes are only ever low inside their own burst states, so these also gate on state.
   assign rx_push = ~rd_q & ~rxf_i;
   assign rx_pop  = rx_valid_o & rx_ready_i;
   assign tx_push = tx_valid_i & tx_ready_o;
   assign tx_pop  = ~wr_q & ~txe_i;

   assign rx_level_nxt = rx_level_o + {{RAW{1'b0}}, rx_push} - {{RAW{1'b0}}, rx_pop};
   assign tx_level_nxt = tx_level_o + {{TAW{1'b0}}, tx_push} - {{TAW{1'b0}}, tx_pop};

   assign rx_req = ~pwren_i & ~rxf_i & (rx_level_o < RxFull);
   assign tx_req = ~pwren_i & ~txe_i & (tx_level_o != '0);

   assign oe_o      = oe_q;
   assign rd_o      = rd_q;
   assign wr_o      = wr_q;
   assign siwu_o    = siwu_q;
   assign data_oe_o = data_oe_q;
   assign data_o    = data_oe_q ? tx_mem[tx_rptr_q[TAW-1:0]] : 8'h00;

   always_ff @(posedge uclk_i) begin
      if (rx_push) rx_mem[rx_wptr_q[RAW-1:0]] <= data_i;
      if (tx_push) tx_mem[tx_wptr_q[TAW-1:0]] <= tx_data_i;
   end

   always_ff @(posedge uclk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         oe_q        <= 1'b1;
         rd_q        <= 1'b1;
         wr_q        <= 1'b1;
         siwu_q      <= 1'b1;
         data_oe_q   <= 1'b0;
         last_tx_q   <= ~TX_FIRST;
         pend_q      <= 1'b0;
         burst_cnt_q <= '0;
         rx_wptr_q   <= '0;
         rx_rptr_q   <= '0;
         tx_wptr_q   <= '0;
         tx_rptr_q   <= '0;
      end else begin
         state_q     <= state_d;
         oe_q        <= oe_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         siwu_q      <= siwu_d;
         data_oe_q   <= data_oe_d;
         last_tx_q   <= last_tx_d;
         pend_q      <= pend_d;
         burst_cnt_q <= burst_cnt_d;
         if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
         if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      oe_d        = 1'b1;
      rd_d        = 1'b1;
      wr_d        = 1'b1;
      siwu_d      = 1'b1;
      data_oe_d   = 1'b0;
      last_tx_d   = last_tx_q;
      burst_cnt_d = burst_cnt_q;
      pend_d      = pend_q | siwu_i;
      unique case (state_q)
         StIdle: begin
            // With both pending, last_tx_q picks the direction not served last.
            if (rx_req && (!tx_req || last_tx_q)) begin
               state_d     = StRxOe;
               oe_d        = 1'b0;
               burst_cnt_d = '0;
               last_tx_d   = 1'b0;
            end else if (tx_req) begin
               state_d     = StTxWr;
               wr_d        = 1'b0;
               data_oe_d   = 1'b1;
               burst_cnt_d = '0;
               last_tx_d   = 1'b1;
            end else if (pend_q && (tx_level_o == '0)) begin
               siwu_d = 1'b0;
               pend_d = 1'b0;
            end
         end
         StRxOe: begin
            state_d = StRxRd;
            oe_d    = 1'b0;
            rd_d    = 1'b0;
         end
         StRxRd: begin
            burst_cnt_d = burst_cnt_q + {7'd0, rx_push};
            if (!rxf_i && !pwren_i && (rx_level_nxt < RxFull) && (burst_cnt_d < MaxBurst)) begin
               oe_d = 1'b0;
               rd_d = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         StTxWr: begin
            burst_cnt_d = burst_cnt_q + {7'd0, tx_pop};
            if (!txe_i && !pwren_i && (tx_level_nxt != '0) && (burst_cnt_d < MaxBurst)) begin
               wr_d      = 1'b0;
               data_oe_d = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_ft245_sync_xcvr.sv
// Bench for ft245_sync_xcvr: FT2232H bus model plus scoreboard queues checked by
// a negedge monitor on both the RX stream and the chip-side TX bus.
module tb_ft245_sync_xcvr;
   localparam int unsigned RxDepth  = 4;
   localparam int unsigned TxDepth  = 8;
   localparam int unsigned MaxBurst = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, pwren = 1'b1, rxf = 1'b1, txe = 1'b1;
   logic       rx_ready = 1'b0, tx_valid = 1'b0, siwu_in = 1'b0;
   logic [7:0] data_in = 8'h00, tx_data = 8'h00;
   logic       oe, rd, wr, siwu_out, data_oe, rx_valid, tx_ready;
   logic [7:0] data_out, rx_data;
   logic [2:0] rx_level;
   logic [3:0] tx_level;

   ft245_sync_xcvr #(
      .RX_DEPTH (RxDepth),
      .TX_DEPTH (TxDepth),
      .MAX_BURST(MaxBurst),
      .TX_FIRST (1'b0)
   ) dut (
      .uclk_i    (clk),
      .rst_i     (rst),
      .pwren_i   (pwren),
      .rxf_i     (rxf),
      .txe_i     (txe),
      .oe_o      (oe),
      .rd_o      (rd),
      .wr_o      (wr),
      .siwu_o    (siwu_out),
      .data_i    (data_in),
      .data_o    (data_out),
      .data_oe_o (data_oe),
      .rx_data_o (rx_data),
      .rx_valid_o(rx_valid),
      .rx_ready_i(rx_ready),
      .tx_data_i (tx_data),
      .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready),
      .siwu_i    (siwu_in),
      .rx_level_o(rx_level),
      .tx_level_o(tx_level)
   );

   int checks = 0, failures = 0;
   logic [7:0] chip_rx_q[$], rx_exp_q[$], tx_exp_q[$];
   int chip_caps = 0, chip_tx_cnt = 0, siwu_lows = 0, bus_viol = 0;
   int oe_falls = 0, wr_falls = 0, run_caps = 0, dir_n = 0;
   logic [31:0] dir_bits = 0;
   logic prev_oe = 1'b1, prev_wr = 1'b1, prev_rd = 1'b1, rd_due = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Chip model: transfers decided from mid-cycle values, bus updated just after the edge.
   always begin : chip_model
      logic cap, acc;
      @(negedge clk);
      cap = !rd && !rxf;
      acc = !wr && !txe;
      @(posedge clk);
      #1;
      if (cap && chip_rx_q.size() > 0) begin
         void'(chip_rx_q.pop_front());
         chip_caps++;
      end
      if (acc) chip_tx_cnt++;
      rxf     = (chip_rx_q.size() == 0);
      data_in = (chip_rx_q.size() > 0) ? chip_rx_q[0] : 8'h00;
   end

   always @(negedge clk) begin : monitor
      if (data_oe && !oe) bus_viol++;
      if (!wr && !oe) bus_viol++;
      if (!siwu_out) siwu_lows++;
      if (prev_oe && !oe) begin
         oe_falls++;
         dir_bits = dir_bits << 1;
         dir_n++;
         check("oe_before_rd", rd, 1);
         rd_due = 1'b1;
      end else if (rd_due) begin
         check("rd_after_oe", rd, 0);
         rd_due = 1'b0;
      end
      if (prev_wr && !wr) begin
         wr_falls++;
         dir_bits = (dir_bits << 1) | 32'd1;
         dir_n++;
      end
      if (!rd && !rxf) run_caps++;
      if (!prev_rd && rd) begin
         check("burst_len_le_max", run_caps <= MaxBurst, 1);
         run_caps = 0;
      end
      if (!rst && rx_valid && rx_ready) begin
         if (rx_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_extra: got %02h expected none", rx_data);
         end else check("rx_data", rx_data, rx_exp_q.pop_front());
      end
      if (!rst && !wr && !txe) begin
         if (tx_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_extra: got %02h expected none", data_out);
         end else check("tx_bus_data", data_out, tx_exp_q.pop_front());
      end
      prev_oe = oe;
      prev_wr = wr;
      prev_rd = rd;
   end

   task automatic load_rx(input logic [7:0] b);
      chip_rx_q.push_back(b);
      rx_exp_q.push_back(b);
   endtask

   task automatic push_tx(input logic [7:0] b);
      int g = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && g < 200) begin
         step();
         g++;
      end
      check("tx_ready_wait", tx_ready, 1);
      tx_exp_q.push_back(b);
      step();
      tx_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int limit);
      int g = 0;
      while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && g < limit) begin
         step();
         g++;
      end
      check(name, rx_exp_q.size() + tx_exp_q.size(), 0);
   endtask

   task automatic wait_low(input string name, input bit use_wr);
      int g = 0;
      while ((use_wr ? wr : rd) && g < 100) begin
         step();
         g++;
      end
      check(name, use_wr ? wr : rd, 0);
   endtask

   initial begin
      step(3);
      check("rst_oe", oe, 1);
      check("rst_rd", rd, 1);
      check("rst_wr", wr, 1);
      check("rst_siwu", siwu_out, 1);
      check("rst_data_oe", data_oe, 0);
      check("rst_data_o", data_out, 0);
      check("rst_rx_valid", rx_valid, 0);
      rst = 1'b0;
      step();
      check("rst_tx_ready", tx_ready, 1);
      check("rst_levels", {rx_level, tx_level}, 0);

      // RX only: 12 bytes in bursts of 5, 5, 2
      pwren = 1'b0;
      rx_ready = 1'b1;
      oe_falls = 0;
      chip_caps = 0;
      for (int i = 0; i < 12; i++) load_rx(8'h10 + 8'(i));
      drain("rx_stream_drain", 200);
      step(5);
      check("rx_burst_count", oe_falls, 3);
      check("rx_caps", chip_caps, 12);
      check("rx_level_empty", rx_level, 0);

      // RX backpressure: FIFO fills at 4 and RD# stays high
      rx_ready = 1'b0;
      chip_caps = 0;
      for (int i = 0; i < 10; i++) load_rx(8'h40 + 8'(i));
      step(30);
      check("bp_level_full", rx_level, 4);
      check("bp_caps", chip_caps, 4);
      check("bp_rd_high", rd, 1);
      check("bp_head", rx_data, 8'h40);
      rx_ready = 1'b1;
      drain("bp_drain", 300);
      check("bp_caps_total", chip_caps, 10);

      // TX with a 3-cycle TXE# stall mid-burst
      txe = 1'b1;
      for (int i = 0; i < 8; i++) push_tx(8'hA0 + 8'(i));
      check("tx_level_full", tx_level, 8);
      check("tx_ready_full", tx_ready, 0);
      chip_tx_cnt = 0;
      txe = 1'b0;
      for (int g = 0; g < 100 && chip_tx_cnt < 3; g++) step();
      check("tx_stall_reached", chip_tx_cnt >= 3, 1);
      txe = 1'b1;
      step(3);
      txe = 1'b0;
      drain("tx_stall_drain", 200);
      step(3);
      check("tx_count", chip_tx_cnt, 8);
      check("tx_level_empty", tx_level, 0);
      check("tx_data_oe_idle", data_oe, 0);

      // Contention after reset: RX, TX, RX, TX
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      pwren = 1'b1;
      for (int i = 0; i < 8; i++) load_rx(8'h60 + 8'(i));
      for (int i = 0; i < 8; i++) push_tx(8'hC0 + 8'(i));
      dir_bits = 0;
      dir_n = 0;
      pwren = 1'b0;
      drain("contention_drain", 300);
      step(5);
      check("contention_bursts", dir_n, 4);
      check("contention_order", dir_bits, 32'h5);

      // SIWU: waits for TX to drain; second pulse while pending absorbed
      txe = 1'b1;
      for (int i = 0; i < 3; i++) push_tx(8'hE0 + 8'(i));
      check("siwu_tx_level", tx_level, 3);
      siwu_lows = 0;
      siwu_in = 1'b1;
      step();
      siwu_in = 1'b0;
      step(5);
      check("siwu_held", siwu_lows, 0);
      siwu_in = 1'b1;
      step();
      siwu_in = 1'b0;
      step(3);
      txe = 1'b0;
      drain("siwu_drain", 100);
      step(10);
      check("siwu_pulses", siwu_lows, 1);

      // Reset in the middle of an RX burst
      rx_ready = 1'b0;
      for (int i = 0; i < 3; i++) load_rx(8'h70 + 8'(i));
      wait_low("rst_rd_low", 1'b0);
      step();
      check("pre_rst_level", rx_level, 1);
      rst = 1'b1;
      step();
      check("midrst_strobes", {oe, rd, wr, siwu_out}, 4'hF);
      check("midrst_data_oe", data_oe, 0);
      check("midrst_levels", {rx_level, tx_level}, 0);
      check("midrst_rx_valid", rx_valid, 0);
      rst = 1'b0;
      rx_exp_q = chip_rx_q;
      rx_ready = 1'b1;
      drain("midrst_drain", 100);

      // PWREN# high during TX_WR ends the burst after one transfer
      txe = 1'b1;
      for (int i = 0; i < 6; i++) push_tx(8'h90 + 8'(i));
      txe = 1'b0;
      wait_low("pwr_wr_low", 1'b1);
      pwren = 1'b1;
      step();
      check("pwr_exit_wr", wr, 1);
      check("pwr_exit_data_oe", data_oe, 0);
      check("pwr_tx_level", tx_level, 5);
      oe_falls = 0;
      wr_falls = 0;
      step(10);
      check("pwr_no_burst", oe_falls + wr_falls, 0);
      pwren = 1'b0;
      drain("pwr_drain", 100);
      check("pwr_tx_level_end", tx_level, 0);

      check("bus_turnaround", bus_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ft245_sync_xcvr.md
# ft245_sync_xcvr

Bidirectional FT2232H FT245 synchronous-FIFO transceiver. It runs entirely in the 60 MHz domain clocked by the FT2232H, and generates OE#, RD# and WR# for half-duplex bursts on the shared 8-bit bus. Internal RX and TX FIFOs present valid/ready byte streams to fabric logic. A round-robin arbiter with a configurable burst limit decides between reading and writing, so neither direction starves the other. The top level owns the tri-state pad: `byte_io = data_oe_o ? data_o : 8'bz`, and `data_i = byte_io`.

## Interface
- RX_DEPTH, 512: RX FIFO entries; power of 2, ≥4.
- TX_DEPTH, 512: TX FIFO entries; power of 2, ≥4.
- MAX_BURST, 64: maximum bytes per burst before returning to IDLE; range 1..255.
- TX_FIRST, 0: arbiter preference after reset; 1 means TX wins the first contention.
- uclk_i  in  1  60 MHz from FT2232H; sole clock. Reset is synchronous, active-high.
- rst_i  in  1  synchronous active-high reset.
- pwren_i  in  1  FT2232H PWREN#; high means the chip is unconfigured and the bus is disabled.
- rxf_i  in  1  RXF#; low means the chip holds readable data.
- txe_i  in  1  TXE#; low means the chip can accept data.
- oe_o  out  1  OE#; active low.
- rd_o  out  1  RD#; active low.
- wr_o  out  1  WR#; active low.
- siwu_o  out  1  SIWU#; active low, one-cycle pulse.
- data_i  in  8  bus input.
- data_o  out  8  bus output.
- data_oe_o  out  1  pad drive enable.
- rx_data_o  out  8  RX stream data.
- rx_valid_o  out  1  RX stream valid.
- rx_ready_i  in  1  RX stream ready.
- tx_data_i  in  8  TX stream data.
- tx_valid_i  in  1  TX stream valid.
- tx_ready_o  out  1  TX stream ready; equals TX FIFO not full.
- siwu_i  in  1  send-immediate request; single-cycle pulse.
- rx_level_o  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- tx_level_o  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.

## Operation
- Reset values:
  - oe_o, rd_o, wr_o, siwu_o = 1.
  - data_oe_o = 0, data_o = 0.
  - Both FIFOs empty; rx_valid_o = 0; levels = 0; tx_ready_o = 1 in the cycle after reset releases.
  - Arbiter preference = TX_FIRST; SIWU pending flag cleared.
- FSM states: IDLE, RX_OE, RX_RD, TX_WR. All strobes are registered outputs of the FSM.
- Request terms, evaluated in IDLE:
  - rx_req = !pwren_i & !rxf_i & (rx_level_o < RX_DEPTH).
  - tx_req = !pwren_i & !txe_i & (tx_level_o ≠ 0).
- Arbitration in IDLE:
  - Only one request active: serve it.
  - Both active: serve the direction not served last.
  - On entering a burst, clear burst_cnt and record the served direction.
- RX_OE: oe_o = 0, rd_o = 1, bus released. Advance unconditionally to RX_RD.
- RX_RD:
  - oe_o = 0, rd_o = 0.
  - Capture condition: a byte is captured into the RX FIFO on any edge where rd_o is low (registered) and rxf_i is low. Each capture increments burst_cnt.
  - Stay in RX_RD only if all of: rxf_i = 0, pwren_i = 0, RX free space after this edge's capture ≥ 1, burst_cnt after this edge < MAX_BURST.
  - Otherwise go to IDLE, with oe_o = rd_o = 1 after the same edge.
  - The RX FIFO never overflows.
- TX_WR:
  - wr_o = 0, data_oe_o = 1, data_o = TX FIFO head.
  - Transfer condition: a byte is popped on any edge where wr_o is low and txe_i is low. If txe_i is high, data_o holds and no pop occurs.
  - Stay in TX_WR only if all of: txe_i = 0, pwren_i = 0, TX occupancy after pop ≥ 1, burst_cnt after this edge < MAX_BURST.
  - Otherwise go to IDLE with wr_o = 1 and data_oe_o = 0.
- Bus turnaround:
  - data_oe_o is never 1 while oe_o is 0.
  - Every burst ends with at least one IDLE cycle.
  - TX_WR is never entered directly from RX states.
- SIWU:
  - siwu_i sets a pending flag.
  - In IDLE with tx_level_o = 0 and no request served that cycle, siwu_o = 0 for exactly one cycle and the flag clears.
  - A siwu_i pulse arriving while the flag is already pending is absorbed.
- FIFOs:
  - Both are first-word-fall-through.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH; the level is computed from pointers with one extra bit.
- pwren_i = 1 blocks new bursts and terminates an active burst at the next edge by the exit rules above.
- rst_i asserted mid-burst forces every output to its reset value after that edge. FIFO contents are discarded.

## Timing
- RX, with rx_req sampled at edge N:
  - oe_o goes low after N.
  - rd_o goes low after N+1.
  - The first capture is at N+2.
  - rx_valid_o rises the cycle after the capture if the FIFO was empty.
- TX, with tx_req sampled at edge N:
  - wr_o goes low and data_oe_o goes high after N.
  - The first transfer is at N+1 if txe_i is low.
- tx_valid_i & tx_ready_o at edge E pushes a byte that is reflected in tx_level_o after E.
- Sustained throughput is 1 byte/cycle within a burst. Minimum burst overhead is 2 cycles for RX (RX_OE plus IDLE) and 1 cycle for TX (IDLE).

## Test plan
- RX only, MAX_BURST=64: rxf_i held low with 100 bytes 0x00..0x63 supplied, rx_ready_i = 1 -> bursts of 64 and 36 bytes. The RX stream delivers 0x00..0x63 in order. oe_o falls exactly one cycle before rd_o in every burst.
- RX backpressure, RX_DEPTH=4: rx_ready_i = 0 while the chip supplies 10 bytes -> exactly 4 bytes captured, rd_o high while full, no overflow. Releasing rx_ready_i then yields all 10 bytes in order.
- TX stall: 8 bytes queued, txe_i pulses high for 3 cycles mid-burst -> the unaccepted byte is held on data_o. The burst ends and resumes later. The chip receives exactly 8 bytes in order with no duplicates.
- Contention: rxf_i and txe_i held low, 200 bytes each way, MAX_BURST=16 -> bursts alternate RX/TX/RX, starting with RX when TX_FIRST=0. No cycle has data_oe_o = 1 while oe_o = 0.
- siwu_i pulsed while tx_level_o = 3 -> siwu_o stays high until the TX FIFO drains and the bus is IDLE, then goes low for exactly 1 cycle. A second pulse while pending produces no extra siwu_o pulse.
- Mid-burst rst_i during RX_RD, and separately pwren_i going high during TX_WR -> for rst_i, all strobes are high and levels are 0 the next cycle. For pwren_i, the burst exits in 1 cycle and no new burst starts while pwren_i = 1.
